// File: rtl/nibble_serial_compare_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial magnitude comparator.
interface nibble_serial_compare_ctrl_if #(
  parameter int WIDTH = 16
);
  localparam int CNT_W = $clog2(WIDTH / 4 + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             gt;
  logic             lt;
  logic             eq;
  logic [CNT_W-1:0] nib_cnt;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, gt, lt, eq, nib_cnt, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, gt, lt, eq, nib_cnt, busy
  );
endinterface

// File: rtl/nibble_serial_compare_ctrl.sv
// Unsigned WIDTH-bit magnitude compare done one nibble per cycle, MSB nibble first,
// through a single shared 4-bit comparator.
module parallel_comparator_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       g,
  output logic       l
);
  assign g = (a > b);
  assign l = (a < b);
endmodule

// state   | meaning
// IDLE    | in_ready high, waiting for an operand pair
// COMPARE | scanning latched operands, one nibble per cycle
// DONE    | out_valid high, result held until out_ready
module nibble_serial_compare_ctrl #(
  parameter int WIDTH      = 16,
  parameter int EARLY_EXIT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  nibble_serial_compare_ctrl_if.slave   bus
);
  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int CNT_W = $clog2(NIB + 1);

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_DONE} state_t;

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] a_q, a_nxt;
  logic [WIDTH-1:0] b_q, b_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [CNT_W-1:0] nib_q, nib_nxt;
  logic             sg_q, sg_nxt;
  logic             sl_q, sl_nxt;
  logic             gt_q, gt_nxt;
  logic             lt_q, lt_nxt;
  logic             eq_q, eq_nxt;

  logic [3:0] a_nib, b_nib;
  logic       cmp_g, cmp_l;

  assign a_nib = 4'(a_q >> {idx_q, 2'b00});
  assign b_nib = 4'(b_q >> {idx_q, 2'b00});

  parallel_comparator_4bit u_cmp (
    .a (a_nib),
    .b (b_nib),
    .g (cmp_g),
    .l (cmp_l)
  );

  always_comb begin
    state_nxt = state_q;
    a_nxt     = a_q;
    b_nxt     = b_q;
    idx_nxt   = idx_q;
    cnt_nxt   = cnt_q;
    nib_nxt   = nib_q;
    sg_nxt    = sg_q;
    sl_nxt    = sl_q;
    gt_nxt    = gt_q;
    lt_nxt    = lt_q;
    eq_nxt    = eq_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_nxt = S_COMPARE;
          a_nxt     = bus.a;
          b_nxt     = bus.b;
          idx_nxt   = IDX_W'(NIB - 1);
          cnt_nxt   = '0;
          nib_nxt   = '0;
          sg_nxt    = 1'b0;
          sl_nxt    = 1'b0;
          gt_nxt    = 1'b0;
          lt_nxt    = 1'b0;
          eq_nxt    = 1'b0;
        end
      end
      S_COMPARE: begin
        cnt_nxt = cnt_q + 1'b1;
        idx_nxt = idx_q - 1'b1;
        // First differing nibble wins; gt has priority if the comparator ever flags both.
        if (!(sg_q || sl_q) && (cmp_g || cmp_l)) begin
          sg_nxt = cmp_g;
          sl_nxt = cmp_l && !cmp_g;
        end
        if ((idx_q == '0) || ((EARLY_EXIT != 0) && (cmp_g || cmp_l))) begin
          state_nxt = S_DONE;
          gt_nxt    = sg_nxt;
          lt_nxt    = sl_nxt;
          eq_nxt    = !(sg_nxt || sl_nxt);
          nib_nxt   = cnt_nxt;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      nib_q   <= '0;
      sg_q    <= 1'b0;
      sl_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      idx_q   <= idx_nxt;
      cnt_q   <= cnt_nxt;
      nib_q   <= nib_nxt;
      sg_q    <= sg_nxt;
      sl_q    <= sl_nxt;
      gt_q    <= gt_nxt;
      lt_q    <= lt_nxt;
      eq_q    <= eq_nxt;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.gt        = gt_q;
  assign bus.lt        = lt_q;
  assign bus.eq        = eq_q;
  assign bus.nib_cnt   = nib_q;

  a_cmp_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_COMPARE) |-> !(cmp_g && cmp_l));
endmodule

// File: tb/tb_nibble_serial_compare_ctrl.sv
// Directed bench: early-exit instance (dut0) and full-scan instance (dut1), WIDTH=16.
module tb_nibble_serial_compare_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc;

  always #5 clk = ~clk;

  nibble_serial_compare_ctrl_if #(.WIDTH(16)) if0 ();
  nibble_serial_compare_ctrl_if #(.WIDTH(16)) if1 ();

  nibble_serial_compare_ctrl #(.WIDTH(16), .EARLY_EXIT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  nibble_serial_compare_ctrl #(.WIDTH(16), .EARLY_EXIT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Counts cycles from just after the accept edge until out_valid is seen, bounded.
  task automatic wait_done(input int sel, output int cycles);
    cycles = 0;
    while (((sel == 0) ? if0.out_valid : if1.out_valid) !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic accept0(input logic [15:0] av, input logic [15:0] bv);
    if0.a = av;
    if0.b = bv;
    if0.in_valid = 1'b1;
    tick();
    if0.in_valid = 1'b0;
  endtask

  task automatic accept1(input logic [15:0] av, input logic [15:0] bv);
    if1.a = av;
    if1.b = bv;
    if1.in_valid = 1'b1;
    tick();
    if1.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.out_ready = 1'b1;
    #23;
    chk("rst_in_ready", 32'(if0.in_ready), 1);
    chk("rst_out_valid", 32'(if0.out_valid), 0);
    chk("rst_flags", 32'({if0.gt, if0.lt, if0.eq}), 0);
    chk("rst_nib_cnt", 32'(if0.nib_cnt), 0);
    chk("rst_busy", 32'(if0.busy), 0);
    rst_n = 1'b1;
    tick();

    // Case 1: MSB nibble differs -> gt after one cycle
    accept0(16'h1234, 16'h0234);
    chk("c1_in_ready_after_accept", 32'(if0.in_ready), 0);
    chk("c1_busy", 32'(if0.busy), 1);
    wait_done(0, cyc);
    chk("c1_latency", 32'(cyc), 1);
    chk("c1_flags", 32'({if0.gt, if0.lt, if0.eq}), 32'b100);
    chk("c1_nib_cnt", 32'(if0.nib_cnt), 1);
    tick();
    chk("c1_back_idle", 32'({if0.out_valid, if0.in_ready}), 32'b01);
    chk("c1_hold_gt", 32'(if0.gt), 1);

    // Case 2: LSB nibble differs -> lt after four cycles; operand change after accept ignored
    accept0(16'hABCA, 16'hABCB);
    chk("c2_cleared_on_accept", 32'({if0.gt, if0.lt, if0.eq, if0.nib_cnt}), 0);
    if0.a = 16'hFFFF;
    wait_done(0, cyc);
    chk("c2_latency", 32'(cyc), 4);
    chk("c2_flags", 32'({if0.gt, if0.lt, if0.eq}), 32'b010);
    chk("c2_nib_cnt", 32'(if0.nib_cnt), 4);
    tick();

    // Case 3: equal operands
    accept0(16'h5A5A, 16'h5A5A);
    wait_done(0, cyc);
    chk("c3_latency", 32'(cyc), 4);
    chk("c3_flags", 32'({if0.gt, if0.lt, if0.eq}), 32'b001);
    chk("c3_nib_cnt", 32'(if0.nib_cnt), 4);
    tick();
    accept0(16'h0000, 16'h0000);
    wait_done(0, cyc);
    chk("c3_zero_flags", 32'({if0.gt, if0.lt, if0.eq}), 32'b001);
    tick();

    // Case 4: back-pressure with a pending new operand pair
    if0.out_ready = 1'b0;
    accept0(16'h1234, 16'h0234);
    wait_done(0, cyc);
    chk("c4_latency", 32'(cyc), 1);
    if0.a = 16'h0001; if0.b = 16'hFFFF; if0.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("c4_hold_valid", 32'(if0.out_valid), 1);
      chk("c4_hold_result", 32'({if0.gt, if0.lt, if0.eq, if0.nib_cnt}), 32'b100_001);
      chk("c4_no_ready", 32'(if0.in_ready), 0);
    end
    if0.out_ready = 1'b1;
    tick();
    chk("c4_release_idle", 32'({if0.out_valid, if0.in_ready}), 32'b01);
    chk("c4_release_hold_gt", 32'(if0.gt), 1);
    tick();
    if0.in_valid = 1'b0;
    chk("c4_accepted", 32'({if0.in_ready, if0.busy}), 32'b01);
    wait_done(0, cyc);
    chk("c4_new_latency", 32'(cyc), 1);
    chk("c4_new_flags", 32'({if0.gt, if0.lt, if0.eq}), 32'b010);
    tick();

    // Case 5: reset mid-compare, then a fresh compare
    accept0(16'hFFF0, 16'hFFF1);
    tick();
    chk("c5_busy_before_rst", 32'(if0.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("c5_rst_valid_busy", 32'({if0.out_valid, if0.busy}), 0);
    chk("c5_rst_in_ready", 32'(if0.in_ready), 1);
    chk("c5_rst_result", 32'({if0.gt, if0.lt, if0.eq, if0.nib_cnt}), 0);
    tick();
    chk("c5_rst_stays_idle", 32'({if0.out_valid, if0.busy}), 0);
    rst_n = 1'b1;
    tick();
    chk("c5_ready_after_release", 32'(if0.in_ready), 1);
    accept0(16'hFFF0, 16'hFFF1);
    wait_done(0, cyc);
    chk("c5_fresh_latency", 32'(cyc), 4);
    chk("c5_fresh_flags", 32'({if0.gt, if0.lt, if0.eq}), 32'b010);
    chk("c5_fresh_nib_cnt", 32'(if0.nib_cnt), 4);
    tick();

    // Case 6: full scan keeps first difference
    accept1(16'h1000, 16'h0FFF);
    wait_done(1, cyc);
    chk("c6_latency", 32'(cyc), 4);
    chk("c6_flags", 32'({if1.gt, if1.lt, if1.eq}), 32'b100);
    chk("c6_nib_cnt", 32'(if1.nib_cnt), 4);
    tick();
    accept1(16'h0FFF, 16'h1000);
    wait_done(1, cyc);
    chk("c6_lt_flags", 32'({if1.gt, if1.lt, if1.eq}), 32'b010);
    chk("c6_lt_nib_cnt", 32'(if1.nib_cnt), 4);
    tick();
    accept1(16'h7777, 16'h7777);
    wait_done(1, cyc);
    chk("c6_eq_flags", 32'({if1.gt, if1.lt, if1.eq}), 32'b001);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
